// File: rtl/trap_unit.sv
// trap_unit: machine-mode trap controller for the RV32 core.
// Arbitrates interrupts, synchronous exceptions and mret, sequences the trap
// CSR writes over the single CSR write port and redirects fetch.
module trap_unit #(
    parameter int XLEN          = 32,
    parameter int NUM_LOCAL_IRQ = 0,
    parameter bit VECTORED_EN   = 1'b1,
    parameter bit EPC_NEXT      = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    irq_sw_i,
    input  logic                    irq_timer_i,
    input  logic                    irq_ext_i,
    input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] irq_local_i,
    input  logic                    ecall_i,
    input  logic                    ebreak_i,
    input  logic                    mret_i,
    input  logic                    illegal_i,
    input  logic [31:0]             inst_i,
    input  logic [XLEN-1:0]         pc_i,
    input  logic                    muldiv_busy_i,
    input  logic [XLEN-1:0]         csr_mtvec_i,
    input  logic [XLEN-1:0]         csr_mepc_i,
    input  logic [XLEN-1:0]         csr_mstatus_i,
    input  logic [XLEN-1:0]         csr_mie_i,
    output logic                    csr_we_o,
    output logic [11:0]             csr_waddr_o,
    output logic [XLEN-1:0]         csr_wdata_o,
    output logic [XLEN-1:0]         mip_o,
    output logic                    stallreq_o,
    output logic [2:0]              flush_o,
    output logic                    jump_req_o,
    output logic [XLEN-1:0]         jump_pc_o,
    output logic                    muldiv_cancel_o
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MCAUSE  = 3'd2,
        S_W_MTVAL   = 3'd3,
        S_W_MSTATUS = 3'd4,
        S_JUMP      = 3'd5,
        S_MRET_MST  = 3'd6,
        S_MRET_JUMP = 3'd7
    } state_e;

    // mstatus image written on trap entry: MPIE<-MIE, MIE<-0, MPP<-M.
    function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        r       = m;
        r[7]    = m[3];
        r[3]    = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    // mstatus image written on mret: MIE<-MPIE, MPIE<-1, MPP<-M.
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] m);
        logic [XLEN-1:0] r;
        r       = m;
        r[3]    = m[7];
        r[7]    = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    state_e            state_q, state_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   tval_q, tval_d;
    logic              is_int_q, is_int_d;
    logic [2:0]        flush_sel_q, flush_sel_d;

    logic [XLEN-1:0]   mip_s;
    logic              glb_en_s;
    logic              loc_any_s;
    logic [4:0]        loc_code_s;
    logic              int_take_s;
    logic [4:0]        int_code_s;
    logic              exc_take_s;
    logic [4:0]        exc_code_s;
    logic              accept_s;
    logic [XLEN-1:0]   tvec_base_s;
    logic [XLEN-1:0]   vec_off_s;
    logic              spare_unused_s;

    // Bits not consumed in this configuration (mie holes, absent local lines).
    assign spare_unused_s = ^{csr_mie_i, irq_local_i};

    // Raw pending view built from the request lines.
    always_comb begin
        mip_s     = {XLEN{1'b0}};
        mip_s[3]  = irq_sw_i;
        mip_s[7]  = irq_timer_i;
        mip_s[11] = irq_ext_i;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            mip_s[16+i] = irq_local_i[i];
        end
    end

    assign mip_o    = mip_s;
    assign glb_en_s = csr_mstatus_i[3];

    // Lowest-index enabled local interrupt (scan high to low, last hit wins).
    always_comb begin
        loc_any_s  = 1'b0;
        loc_code_s = 5'd0;
        for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
            loc_any_s  = loc_any_s | (mip_s[16+i] & csr_mie_i[16+i]);
            loc_code_s = (mip_s[16+i] & csr_mie_i[16+i]) ? 5'(16 + i) : loc_code_s;
        end
    end

    // Interrupt arbitration: ext > sw > timer > local.
    always_comb begin
        int_take_s = glb_en_s;
        if (glb_en_s && mip_s[11] && csr_mie_i[11]) begin
            int_code_s = 5'd11;
        end else if (glb_en_s && mip_s[3] && csr_mie_i[3]) begin
            int_code_s = 5'd3;
        end else if (glb_en_s && mip_s[7] && csr_mie_i[7]) begin
            int_code_s = 5'd7;
        end else if (glb_en_s && loc_any_s) begin
            int_code_s = loc_code_s;
        end else begin
            int_take_s = 1'b0;
            int_code_s = 5'd0;
        end
    end

    // Exception arbitration: illegal > ebreak > ecall.
    always_comb begin
        exc_take_s = 1'b1;
        if (illegal_i) begin
            exc_code_s = 5'd2;
        end else if (ebreak_i) begin
            exc_code_s = 5'd3;
        end else if (ecall_i) begin
            exc_code_s = 5'd11;
        end else begin
            exc_take_s = 1'b0;
            exc_code_s = 5'd0;
        end
    end

    assign accept_s   = (state_q == S_IDLE) & (int_take_s | exc_take_s | mret_i);
    assign stallreq_o = (state_q != S_IDLE) | accept_s;

    // Next-state and trap-context capture; context is latched only on accept.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        tval_d      = tval_q;
        is_int_d    = is_int_q;
        flush_sel_d = flush_sel_q;
        case (state_q)
            S_IDLE: begin
                if (int_take_s) begin
                    state_d        = S_W_MEPC;
                    is_int_d       = 1'b1;
                    cause_d        = {XLEN{1'b0}};
                    cause_d[XLEN-1] = 1'b1;
                    cause_d[4:0]   = int_code_s;
                    epc_d          = muldiv_busy_i ? (pc_i - PC_STEP) : pc_i;
                    tval_d         = {XLEN{1'b0}};
                    flush_sel_d    = muldiv_busy_i ? 3'b010 : 3'b100;
                end else if (exc_take_s) begin
                    state_d      = S_W_MEPC;
                    is_int_d     = 1'b0;
                    cause_d      = {XLEN{1'b0}};
                    cause_d[4:0] = exc_code_s;
                    epc_d        = EPC_NEXT ? (pc_i + PC_STEP) : pc_i;
                    tval_d       = illegal_i ? XLEN'(inst_i) : {XLEN{1'b0}};
                    flush_sel_d  = 3'b001;
                end else if (mret_i) begin
                    state_d     = S_MRET_MST;
                    is_int_d    = 1'b0;
                    flush_sel_d = 3'b001;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_W_MEPC:    state_d = S_W_MCAUSE;
            S_W_MCAUSE:  state_d = S_W_MTVAL;
            S_W_MTVAL:   state_d = S_W_MSTATUS;
            S_W_MSTATUS: state_d = S_JUMP;
            S_JUMP:      state_d = S_IDLE;
            S_MRET_MST:  state_d = S_MRET_JUMP;
            S_MRET_JUMP: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    assign tvec_base_s = {csr_mtvec_i[XLEN-1:2], 2'b00};
    assign vec_off_s   = {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};

    // CSR write port, flush and redirect decoded from the registered state.
    always_comb begin
        csr_we_o    = 1'b0;
        csr_waddr_o = 12'h000;
        csr_wdata_o = {XLEN{1'b0}};
        flush_o     = 3'b000;
        jump_req_o  = 1'b0;
        jump_pc_o   = {XLEN{1'b0}};
        case (state_q)
            S_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MEPC;
                csr_wdata_o = epc_q;
                flush_o     = flush_sel_q;
            end
            S_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MCAUSE;
                csr_wdata_o = cause_q;
            end
            S_W_MTVAL: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MTVAL;
                csr_wdata_o = tval_q;
            end
            S_W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = trap_mstatus(csr_mstatus_i);
            end
            S_JUMP: begin
                jump_req_o = 1'b1;
                if (VECTORED_EN && is_int_q && (csr_mtvec_i[1:0] == 2'b01)) begin
                    jump_pc_o = tvec_base_s + vec_off_s;
                end else begin
                    jump_pc_o = tvec_base_s;
                end
            end
            S_MRET_MST: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = ADDR_MSTATUS;
                csr_wdata_o = mret_mstatus(csr_mstatus_i);
                flush_o     = flush_sel_q;
            end
            S_MRET_JUMP: begin
                jump_req_o = 1'b1;
                jump_pc_o  = csr_mepc_i;
            end
            default: begin
                csr_we_o = 1'b0;
            end
        endcase
    end

    assign muldiv_cancel_o = flush_o[1];

    // State and trap-context registers; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cause_q     <= {XLEN{1'b0}};
            epc_q       <= {XLEN{1'b0}};
            tval_q      <= {XLEN{1'b0}};
            is_int_q    <= 1'b0;
            flush_sel_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            tval_q      <= tval_d;
            is_int_q    <= is_int_d;
            flush_sel_q <= flush_sel_d;
        end
    end

endmodule

// File: tb/tb_trap_unit.sv
// tb_trap_unit: directed bench for trap_unit with a behavioural reference model
// and a per-cycle compare process.
module tb_trap_unit;

    localparam int NL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          irq_sw, irq_timer, irq_ext;
    logic [NL-1:0] irq_local;
    logic          ecall, ebreak, mret, illegal, busy;
    logic [31:0]   inst, pc, mtvec, mepc, mstatus, mie;

    logic          csr_we_o, stallreq_o, jump_req_o, muldiv_cancel_o;
    logic [11:0]   csr_waddr_o;
    logic [31:0]   csr_wdata_o, mip_o, jump_pc_o;
    logic [2:0]    flush_o;

    trap_unit #(
        .XLEN(32), .NUM_LOCAL_IRQ(NL), .VECTORED_EN(1'b1), .EPC_NEXT(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .irq_sw_i(irq_sw), .irq_timer_i(irq_timer), .irq_ext_i(irq_ext),
        .irq_local_i(irq_local),
        .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret), .illegal_i(illegal),
        .inst_i(inst), .pc_i(pc), .muldiv_busy_i(busy),
        .csr_mtvec_i(mtvec), .csr_mepc_i(mepc), .csr_mstatus_i(mstatus), .csr_mie_i(mie),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .mip_o(mip_o), .stallreq_o(stallreq_o), .flush_o(flush_o),
        .jump_req_o(jump_req_o), .jump_pc_o(jump_pc_o), .muldiv_cancel_o(muldiv_cancel_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic [2:0]  flush;
        logic        jump;
        logic [31:0] jpc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] seen[int];
    logic [31:0] last_jpc;
    int          wr_cnt = 0;
    int          jmp_cnt = 0;
    int          cancel_cnt = 0;
    logic [31:0] model_cause, model_epc, model_target;

    function automatic exp_t mk(input logic stall, input logic we, input logic [11:0] addr,
                                input logic [31:0] data, input logic [2:0] flush,
                                input logic jump, input logic [31:0] jpc);
        exp_t e;
        e.stall = stall; e.we = we; e.addr = addr; e.data = data;
        e.flush = flush; e.jump = jump; e.jpc = jpc;
        return e;
    endfunction

    function automatic logic [31:0] mip_model();
        logic [31:0] v;
        v = 32'd0;
        v[3] = irq_sw; v[7] = irq_timer; v[11] = irq_ext;
        for (int i = 0; i < NL; i++) v[16+i] = irq_local[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: from the current inputs, list the expected outputs of
    // every cycle from the accept cycle to the redirect.
    task automatic predict(output int len);
        int          prio[$];
        int          code;
        logic [31:0] pend, cause, epc, tval, target, mst;
        logic [2:0]  fs;
        len = 0; code = -1;
        cause = 32'd0; epc = 32'd0; tval = 32'd0; target = 32'd0; fs = 3'b000;
        pend = mip_model();
        prio.push_back(11); prio.push_back(3); prio.push_back(7);
        for (int i = 0; i < NL; i++) prio.push_back(16 + i);
        if (mstatus[3]) begin
            foreach (prio[k]) begin
                if (code < 0 && pend[prio[k]] && mie[prio[k]]) code = prio[k];
            end
        end
        if (code >= 0) begin
            cause  = 32'h8000_0000 | 32'(code);
            epc    = busy ? pc - 32'd4 : pc;
            tval   = 32'd0;
            fs     = busy ? 3'b010 : 3'b100;
            target = {mtvec[31:2], 2'b00} + ((mtvec[1:0] == 2'b01) ? 32'(4 * code) : 32'd0);
        end else if (illegal || ebreak || ecall) begin
            code   = illegal ? 2 : (ebreak ? 3 : 11);
            cause  = 32'(code);
            epc    = pc;
            tval   = illegal ? inst : 32'd0;
            fs     = 3'b001;
            target = {mtvec[31:2], 2'b00};
        end
        if (code >= 0) begin
            mst = (mstatus & ~32'h1888) | (mstatus[3] ? 32'h80 : 32'h0) | 32'h1800;
            exp_q.push_back(mk(1'b1, 1'b0, 12'h000, 32'd0, 3'b000, 1'b0, 32'd0));
            exp_q.push_back(mk(1'b1, 1'b1, 12'h341, epc,   fs,     1'b0, 32'd0));
            exp_q.push_back(mk(1'b1, 1'b1, 12'h342, cause, 3'b000, 1'b0, 32'd0));
            exp_q.push_back(mk(1'b1, 1'b1, 12'h343, tval,  3'b000, 1'b0, 32'd0));
            exp_q.push_back(mk(1'b1, 1'b1, 12'h300, mst,   3'b000, 1'b0, 32'd0));
            exp_q.push_back(mk(1'b1, 1'b0, 12'h000, 32'd0, 3'b000, 1'b1, target));
            len = 6;
            model_cause = cause; model_epc = epc; model_target = target;
        end else if (mret) begin
            mst = (mstatus & ~32'h1888) | (mstatus[7] ? 32'h8 : 32'h0) | 32'h1880;
            exp_q.push_back(mk(1'b1, 1'b0, 12'h000, 32'd0, 3'b000, 1'b0, 32'd0));
            exp_q.push_back(mk(1'b1, 1'b1, 12'h300, mst,   3'b001, 1'b0, 32'd0));
            exp_q.push_back(mk(1'b1, 1'b0, 12'h000, 32'd0, 3'b000, 1'b1, mepc));
            len = 3;
            model_target = mepc;
        end
    endtask

    // Compare every cycle on the falling edge; with nothing expected the unit must be idle.
    always @(negedge clk) begin : cmp
        exp_t e;
        e = mk(1'b0, 1'b0, 12'h000, 32'd0, 3'b000, 1'b0, 32'd0);
        if (rst_n && exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (stallreq_o !== e.stall || csr_we_o !== e.we || csr_waddr_o !== e.addr ||
            csr_wdata_o !== e.data || flush_o !== e.flush || jump_req_o !== e.jump ||
            jump_pc_o !== e.jpc || muldiv_cancel_o !== e.flush[1]) begin
            errors++;
            $display("FAIL outputs @%0t: got stall=%b we=%b addr=%h data=%h flush=%b jump=%b jpc=%h cancel=%b expected stall=%b we=%b addr=%h data=%h flush=%b jump=%b jpc=%h",
                     $time, stallreq_o, csr_we_o, csr_waddr_o, csr_wdata_o, flush_o, jump_req_o,
                     jump_pc_o, muldiv_cancel_o, e.stall, e.we, e.addr, e.data, e.flush, e.jump, e.jpc);
        end
        checks++;
        if (mip_o !== mip_model()) begin
            errors++;
            $display("FAIL mip @%0t: got %h expected %h", $time, mip_o, mip_model());
        end
        if (csr_we_o) begin
            seen[int'(csr_waddr_o)] = csr_wdata_o;
            wr_cnt++;
        end
        if (jump_req_o) begin
            last_jpc = jump_pc_o;
            jmp_cnt++;
        end
        if (muldiv_cancel_o) cancel_cnt++;
    end

    task automatic clear_events();
        irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0; irq_local = '0;
        ecall = 1'b0; ebreak = 1'b0; mret = 1'b0; illegal = 1'b0; busy = 1'b0;
    endtask

    // Inputs are already applied (just after a rising edge); hold them through
    // the sequence, drop them in its last cycle, then allow one idle cycle.
    task automatic run();
        int len;
        predict(len);
        if (len > 0) begin
            repeat (len - 1) @(posedge clk);
            #1;
        end
        clear_events();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("trace_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int c0, w0, j0, len;
        clear_events();
        inst = 32'd0; pc = 32'd0; mtvec = 32'h800; mepc = 32'd0;
        mstatus = 32'h8; mie = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // T1: ecall, direct mtvec
        ecall = 1'b1; pc = 32'h100; run();
        chk("t1_model_cause", model_cause, 32'h0000_000B);
        chk("t1_mepc", seen[12'h341], 32'h100);
        chk("t1_mcause", seen[12'h342], 32'hB);
        chk("t1_mtval", seen[12'h343], 32'h0);
        chk("t1_mstatus", seen[12'h300], 32'h1880);
        chk("t1_jump", last_jpc, 32'h800);

        // T2: timer interrupt, vectored
        mtvec = 32'h801; irq_timer = 1'b1; pc = 32'h200; run();
        chk("t2_model_target", model_target, 32'h81C);
        chk("t2_mcause", seen[12'h342], 32'h8000_0007);
        chk("t2_jump", last_jpc, 32'h81C);

        // T3: timer interrupt with mul/div in flight
        c0 = cancel_cnt;
        mtvec = 32'h800; irq_timer = 1'b1; busy = 1'b1; pc = 32'h204; run();
        chk("t3_model_epc", model_epc, 32'h200);
        chk("t3_mepc", seen[12'h341], 32'h200);
        chk("t3_cancel_pulses", 32'(cancel_cnt - c0), 32'd1);

        // T4: ext + sw + local0 together, then mret, then the next trap
        irq_ext = 1'b1; irq_sw = 1'b1; irq_local = 2'b01; pc = 32'h240; run();
        chk("t4_mcause_ext", seen[12'h342], 32'h8000_000B);
        irq_sw = 1'b1; irq_local = 2'b01; mstatus = 32'h80; mepc = 32'h240; mret = 1'b1; run();
        chk("t4_mret_mstatus", seen[12'h300], 32'h1888);
        mstatus = 32'h8; irq_sw = 1'b1; irq_local = 2'b01; pc = 32'h240; run();
        chk("t4_mcause_sw", seen[12'h342], 32'h8000_0003);

        // T5: illegal instruction; exceptions never vector
        mtvec = 32'h801; illegal = 1'b1; inst = 32'hFFFF_FFFF; pc = 32'h300; run();
        chk("t5_mcause", seen[12'h342], 32'h2);
        chk("t5_mtval", seen[12'h343], 32'hFFFF_FFFF);
        chk("t5_jump", last_jpc, 32'h800);
        mtvec = 32'h800; inst = 32'd0;

        // T6: mret
        mepc = 32'h104; mstatus = 32'h80; mret = 1'b1; run();
        chk("t6_mstatus", seen[12'h300], 32'h1888);
        chk("t6_jump", last_jpc, 32'h104);
        mstatus = 32'h8;

        // ecall and timer together: interrupt wins, mepc is the ecall pc
        ecall = 1'b1; irq_timer = 1'b1; pc = 32'h400; run();
        chk("both_mcause", seen[12'h342], 32'h8000_0007);
        chk("both_mepc", seen[12'h341], 32'h400);

        // mret with a pending enabled interrupt: interrupt taken instead
        mret = 1'b1; irq_timer = 1'b1; pc = 32'h410; run();
        chk("mret_irq_mcause", seen[12'h342], 32'h8000_0007);
        chk("mret_irq_mstatus", seen[12'h300], 32'h1880);

        // MIE clear: nothing happens, pending still visible
        mstatus = 32'h0; irq_timer = 1'b1;
        @(negedge clk);
        chk("mie0_mip", mip_o, 32'h80);
        chk("mie0_stall", 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        run();
        mstatus = 32'h8;

        // local1 only, vectored: cause 17, target base + 0x44
        mtvec = 32'h801; irq_local = 2'b10; run();
        chk("loc1_mcause", seen[12'h342], 32'h8000_0011);
        chk("loc1_jump", last_jpc, 32'h844);
        mtvec = 32'h800;

        // masked ext with enabled timer, then all exceptions together, then ebreak
        mie = 32'h80; irq_ext = 1'b1; irq_timer = 1'b1; run();
        chk("mask_mcause", seen[12'h342], 32'h8000_0007);
        mie = 32'hFFFF_FFFF;
        illegal = 1'b1; ebreak = 1'b1; ecall = 1'b1; inst = 32'h1234_5678; run();
        chk("excprio_mcause", seen[12'h342], 32'h2);
        ebreak = 1'b1; ecall = 1'b1; run();
        chk("ebreak_mcause", seen[12'h342], 32'h3);

        // T7: reset while writing mcause
        ecall = 1'b1; pc = 32'h500; predict(len);
        @(posedge clk); #1;
        @(posedge clk); #2;
        w0 = wr_cnt; j0 = jmp_cnt;
        rst_n = 1'b0; clear_events(); exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
        chk("rst_writes", 32'(wr_cnt - w0), 32'd0);
        chk("rst_jumps", 32'(jmp_cnt - j0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // trap after reset recovery
        ecall = 1'b1; pc = 32'h600; run();
        chk("post_rst_mepc", seen[12'h341], 32'h600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
